// File: rtl/stride_pkg.sv
// Shared types and default sizes for the stride counter arbiter.
package stride_pkg;
  localparam int W_DEF     = 3;
  localparam int LEN_W_DEF = 4;
  localparam int N_CH      = 2;

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;
endpackage

// File: rtl/stride_counter.sv
// Modulo stride counter: clears on load, otherwise adds step and returns to 0
// only when the current value equals wrap exactly.
module stride_counter
  import stride_pkg::*;
#(
  parameter int W = W_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] step,
  input  logic [W-1:0] wrap,
  output logic [W-1:0] q
);

  logic [W-1:0] sum;
  logic [W-1:0] q_next;

  // A sum that jumps past wrap simply rolls over modulo 2^W.
  always_comb begin
    sum    = q + step;
    q_next = (q == wrap) ? '0 : sum;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    q <= '0;
    else if (load) q <= '0;
    else if (en)   q <= q_next;
  end

endmodule

// File: rtl/stride_counter_arbiter.sv
// Round-robin sequencer sharing one stride counter between two requesters;
// each grant streams len counter values tagged with the owning channel.
module stride_counter_arbiter
  import stride_pkg::*;
#(
  parameter int W     = W_DEF,
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] req,
  input  logic [W-1:0]    step0,
  input  logic [W-1:0]    step1,
  input  logic [W-1:0]    wrap0,
  input  logic [W-1:0]    wrap1,
  input  logic [LEN_W-1:0] len0,
  input  logic [LEN_W-1:0] len1,
  output logic [N_CH-1:0] gnt,
  output logic            busy,
  output logic            q_valid,
  output logic [W-1:0]    q,
  output logic            q_owner,
  output logic [N_CH-1:0] done
);

  state_t           state, state_n;
  logic             owner, owner_n;
  logic             last_owner, last_owner_n;
  logic [LEN_W-1:0] remain, remain_n;
  logic [W-1:0]     step_r, wrap_r;
  logic             accept;
  logic             sel;
  logic             run;
  logic             last_cyc;
  logic [N_CH-1:0]  onehot;

  assign run      = (state == RUN);
  assign last_cyc = (remain <= LEN_W'(1));
  assign sel      = (req[0] & req[1]) ? ~last_owner : req[1];
  assign onehot   = N_CH'(1) << owner;

  always_comb begin
    state_n      = state;
    owner_n      = owner;
    last_owner_n = last_owner;
    remain_n     = remain;
    accept       = 1'b0;
    case (state)
      IDLE: begin
        if (|req) begin
          accept   = 1'b1;
          owner_n  = sel;
          remain_n = sel ? len1 : len0;
          state_n  = RUN;
        end
      end
      RUN: begin
        if (remain != '0) remain_n = remain - LEN_W'(1);
        // Dropping the owner's request abandons the burst without a done pulse.
        if (!req[owner] || last_cyc) begin
          state_n      = IDLE;
          last_owner_n = owner;
          remain_n     = '0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      remain     <= '0;
    end else begin
      state      <= state_n;
      owner      <= owner_n;
      last_owner <= last_owner_n;
      remain     <= remain_n;
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      step_r <= sel ? step1 : step0;
      wrap_r <= sel ? wrap1 : wrap0;
    end
  end

  stride_counter #(.W(W)) u_counter (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (accept),
    .en    (run),
    .step  (step_r),
    .wrap  (wrap_r),
    .q     (q)
  );

  assign busy    = run;
  assign gnt     = run ? onehot : '0;
  assign q_valid = run && (remain != '0);
  assign q_owner = run & owner;
  assign done    = (run && last_cyc) ? onehot : '0;

endmodule

// File: tb/tb_stride_counter_arbiter.sv
// Self-checking bench for stride_counter_arbiter against a burst-level model.
module tb_stride_counter_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req;
  logic [2:0] step0, step1, wrap0, wrap1;
  logic [3:0] len0, len1;
  logic [1:0] gnt, done;
  logic       busy, q_valid, q_owner;
  logic [2:0] q;

  int errors = 0;
  int checks = 0;
  int m_last = 1;
  int cs[2];
  int cw[2];
  int cl[2];

  always #5 clk = ~clk;

  stride_counter_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req(req),
    .step0(step0), .step1(step1), .wrap0(wrap0), .wrap1(wrap1),
    .len0(len0), .len1(len1),
    .gnt(gnt), .busy(busy), .q_valid(q_valid), .q(q),
    .q_owner(q_owner), .done(done)
  );

  // k-th emitted value of a burst: start at 0, reset on hitting wrap, else add step mod 8.
  function automatic int model_q(input int s, input int w, input int k);
    int v;
    v = 0;
    for (int i = 0; i < k; i++) v = (v == w) ? 0 : (v + s) % 8;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int ch, input int s, input int w, input int l);
    cs[ch] = s; cw[ch] = w; cl[ch] = l;
    if (ch == 0) begin step0 = 3'(s); wrap0 = 3'(w); len0 = 4'(l); end
    else         begin step1 = 3'(s); wrap1 = 3'(w); len1 = 4'(l); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 2'b00;
    set_cfg(0, 0, 0, 0); set_cfg(1, 0, 0, 0);
    #2;
    checks++;
    if ({gnt, busy, q_valid, q_owner, done, q} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=0", {gnt, busy, q_valid, q_owner, done, q});
    end
    tick(); tick();
    rst_n = 1'b1; m_last = 1;
    tick();
    checks++;
    if ({gnt, busy, q_valid, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_idle got=%b exp=0", {gnt, busy, q_valid, done});
    end
  endtask

  task automatic test_single_bursts();
    int t_ch[6] = '{0, 1, 0, 0, 1, 1};
    int t_st[6] = '{3, 2, 3, 3, 5, 7};
    int t_wr[6] = '{6, 6, 5, 5, 7, 7};
    int t_ln[6] = '{5, 5, 4, 0, 0, 9};
    for (int b = 0; b < 6; b++) begin
      int ch;
      int n;
      logic [6:0] exp_c;
      ch = t_ch[b];
      set_cfg(ch, t_st[b], t_wr[b], t_ln[b]);
      req = 2'(1 << ch);
      tick();
      n = (t_ln[b] == 0) ? 1 : t_ln[b];
      for (int k = 0; k < n; k++) begin
        exp_c = {2'(1 << ch), 1'b1, t_ln[b] != 0, 1'(ch), (k == n - 1) ? 2'(1 << ch) : 2'b00};
        checks++;
        if ({gnt, busy, q_valid, q_owner, done} !== exp_c) begin
          errors++;
          $display("FAIL single_ctrl b=%0d k=%0d got=%b exp=%b", b, k,
                   {gnt, busy, q_valid, q_owner, done}, exp_c);
        end
        if (t_ln[b] != 0) begin
          checks++;
          if (q !== 3'(model_q(t_st[b], t_wr[b], k))) begin
            errors++;
            $display("FAIL single_q b=%0d k=%0d got=%0d exp=%0d", b, k, q,
                     model_q(t_st[b], t_wr[b], k));
          end
        end
        if (k == n - 1) req = 2'b00;
        tick();
      end
      checks++;
      if ({gnt, busy, done} !== 5'b0) begin
        errors++;
        $display("FAIL single_idle b=%0d got=%b exp=0", b, {gnt, busy, done});
      end
      m_last = ch;
    end
  endtask

  task automatic test_round_robin();
    int exp_ch;
    logic [6:0] exp_c;
    rst_n = 1'b0; req = 2'b00;
    tick();
    rst_n = 1'b1; m_last = 1;
    set_cfg(0, $urandom_range(1, 7), $urandom_range(0, 7), 2);
    set_cfg(1, $urandom_range(1, 7), $urandom_range(0, 7), 2);
    req = 2'b11;
    tick();
    for (int b = 0; b < 3; b++) begin
      exp_ch = 1 - m_last;
      for (int k = 0; k < 2; k++) begin
        exp_c = {2'(1 << exp_ch), 1'b1, 1'b1, 1'(exp_ch), (k == 1) ? 2'(1 << exp_ch) : 2'b00};
        checks++;
        if ({gnt, busy, q_valid, q_owner, done} !== exp_c) begin
          errors++;
          $display("FAIL rr_ctrl b=%0d k=%0d got=%b exp=%b", b, k,
                   {gnt, busy, q_valid, q_owner, done}, exp_c);
        end
        checks++;
        if (q !== 3'(model_q(cs[exp_ch], cw[exp_ch], k))) begin
          errors++;
          $display("FAIL rr_q b=%0d k=%0d got=%0d exp=%0d", b, k, q,
                   model_q(cs[exp_ch], cw[exp_ch], k));
        end
        if (b == 2 && k == 1) req = 2'b00;
        tick();
      end
      m_last = exp_ch;
      checks++;
      if ({gnt, busy} !== 3'b0) begin
        errors++;
        $display("FAIL rr_gap b=%0d got=%b exp=0", b, {gnt, busy});
      end
      if (b < 2) tick();
    end
  endtask

  task automatic test_abort();
    set_cfg(0, 1, 7, 6); set_cfg(1, 3, 4, 1);
    req = 2'b01;
    tick();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({gnt, busy, q_valid, q_owner, done, q} !== {7'b0111000, 3'(k)}) begin
        errors++;
        $display("FAIL abort_run k=%0d got=%b exp=%b", k,
                 {gnt, busy, q_valid, q_owner, done, q}, {7'b0111000, 3'(k)});
      end
      req = (k == 0) ? 2'b11 : 2'b10;
      tick();
    end
    checks++;
    if ({gnt, busy, q_valid, done} !== 6'b0) begin
      errors++;
      $display("FAIL abort_idle got=%b exp=0", {gnt, busy, q_valid, done});
    end
    m_last = 0;
    tick();
    checks++;
    if ({gnt, busy, q_valid, q_owner, done, q} !== {7'b1011110, 3'd0}) begin
      errors++;
      $display("FAIL abort_next got=%b exp=%b", {gnt, busy, q_valid, q_owner, done, q},
               {7'b1011110, 3'd0});
    end
    req = 2'b00;
    tick();
    m_last = 1;
    checks++;
    if ({gnt, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL abort_end got=%b exp=0", {gnt, busy, done});
    end
  endtask

  task automatic test_reset_midburst();
    set_cfg(0, 1, 7, 6); set_cfg(1, 2, 7, 3);
    req = 2'b01;
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, busy, q_valid, q_owner, done, q} !== 10'b0) begin
      errors++;
      $display("FAIL midreset_async got=%b exp=0", {gnt, busy, q_valid, q_owner, done, q});
    end
    tick();
    req = 2'b11;
    rst_n = 1'b1; m_last = 1;
    tick();
    checks++;
    if ({gnt, busy, q_valid, q_owner, done, q} !== {7'b0111000, 3'd0}) begin
      errors++;
      $display("FAIL midreset_first got=%b exp=%b", {gnt, busy, q_valid, q_owner, done, q},
               {7'b0111000, 3'd0});
    end
    req = 2'b00;
    tick();
    m_last = 0;
    checks++;
    if ({gnt, busy, done} !== 5'b0) begin
      errors++;
      $display("FAIL midreset_abort got=%b exp=0", {gnt, busy, done});
    end
  endtask

  task automatic test_random();
    int mode;
    int own;
    int n;
    logic [6:0] exp_c;
    for (int b = 0; b < 25; b++) begin
      mode = $urandom_range(0, 2);
      set_cfg(0, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 6));
      set_cfg(1, $urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 6));
      req = (mode == 0) ? 2'b01 : (mode == 1) ? 2'b10 : 2'b11;
      own = (mode == 2) ? 1 - m_last : mode;
      tick();
      n = (cl[own] == 0) ? 1 : cl[own];
      for (int k = 0; k < n; k++) begin
        exp_c = {2'(1 << own), 1'b1, cl[own] != 0, 1'(own), (k == n - 1) ? 2'(1 << own) : 2'b00};
        checks++;
        if ({gnt, busy, q_valid, q_owner, done} !== exp_c) begin
          errors++;
          $display("FAIL rand_ctrl b=%0d k=%0d got=%b exp=%b", b, k,
                   {gnt, busy, q_valid, q_owner, done}, exp_c);
        end
        if (cl[own] != 0) begin
          checks++;
          if (q !== 3'(model_q(cs[own], cw[own], k))) begin
            errors++;
            $display("FAIL rand_q b=%0d k=%0d got=%0d exp=%0d", b, k, q,
                     model_q(cs[own], cw[own], k));
          end
        end
        if (k == n - 1) req = 2'b00;
        tick();
      end
      m_last = own;
      checks++;
      if ({gnt, busy, done} !== 5'b0) begin
        errors++;
        $display("FAIL rand_idle b=%0d got=%b exp=0", b, {gnt, busy, done});
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_bursts();
    test_round_robin();
    test_abort();
    test_reset_midburst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
